// File: rtl/dac_seq_pkg.sv
// rtl/dac_seq_pkg.sv - shared state encoding, default widths and clock rate for the DAC sequencer
package dac_seq_pkg;

    localparam int DAC_SEQ_ADDR_W = 14;
    localparam int DAC_SEQ_PRI_W  = 32;
    localparam int DAC_SEQ_NP_W   = 16;

    // Reference clock rate, shared with the pps/timebase blocks
    localparam int unsigned REF_CLK_HZ = 32'd215040000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } dac_seq_state_e;

endpackage

// File: rtl/dac_sequencer_if.sv
// rtl/dac_sequencer_if.sv - timebase/config/DAC-port bundle for dac_sequencer (late_cnt under DAC_SEQ_LATE_CNT_EN)
interface dac_sequencer_if
    import dac_seq_pkg::*;
#(
    parameter int ADDR_W = DAC_SEQ_ADDR_W,
    parameter int PRI_W  = DAC_SEQ_PRI_W,
    parameter int NP_W   = DAC_SEQ_NP_W
);
    logic              tic;
    logic [31:0]       sec;
    logic              arm;
    logic              abort;
    logic [31:0]       start_sec;
    logic [PRI_W-1:0]  pri_cycles;
    logic [ADDR_W-1:0] wave_len;
    logic [NP_W-1:0]   num_pulses;
    logic [ADDR_W-1:0] dac_addr;
    logic              dac_en;
    logic              pulse_start;
    logic              busy;
    logic              done;
    logic              late_err;
`ifdef DAC_SEQ_LATE_CNT_EN
    logic [15:0]       late_cnt;
`endif

    modport master (
        output tic, sec, arm, abort, start_sec, pri_cycles, wave_len, num_pulses,
`ifdef DAC_SEQ_LATE_CNT_EN
        input  late_cnt,
`endif
        input  dac_addr, dac_en, pulse_start, busy, done, late_err
    );

    modport slave (
        input  tic, sec, arm, abort, start_sec, pri_cycles, wave_len, num_pulses,
`ifdef DAC_SEQ_LATE_CNT_EN
        output late_cnt,
`endif
        output dac_addr, dac_en, pulse_start, busy, done, late_err
    );

endinterface

// File: rtl/dac_seq_pri_cnt.sv
// rtl/dac_seq_pri_cnt.sv - PRI cycle counter with load, enable and terminal-count strobe
module dac_seq_pri_cnt
    import dac_seq_pkg::*;
#(
    parameter int W = DAC_SEQ_PRI_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tc = i_en && (r_cnt == i_last);

endmodule

// File: rtl/dac_sequencer.sv
// rtl/dac_sequencer.sv - PPS-aligned DAC waveform sequencer with PRI repeat; DAC_SEQ_LATE_CNT_EN adds late_cnt
module dac_sequencer
    import dac_seq_pkg::*;
#(
    parameter int ADDR_W = DAC_SEQ_ADDR_W,
    parameter int PRI_W  = DAC_SEQ_PRI_W,
    parameter int NP_W   = DAC_SEQ_NP_W
) (
    input  logic           clk,
    input  logic           rst,
    dac_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ARMED = ST_ARMED;
    localparam logic [1:0] S_PLAY  = ST_PLAY;
    localparam logic [1:0] S_GAP   = ST_GAP;

    logic [1:0]        r_state;
    logic [31:0]       r_start_sec;
    logic [ADDR_W-1:0] r_l_last;
    logic [PRI_W-1:0]  r_p_last;
    logic [NP_W-1:0]   r_num;
    logic [NP_W-1:0]   r_pulse_cnt;
    logic [ADDR_W-1:0] r_dac_addr;
    logic              r_dac_en;
    logic              r_pulse_start;
    logic              r_busy;
    logic              r_done;
    logic              r_late_err;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_len;
    logic [PRI_W-1:0]  w_len_ext;
    logic [PRI_W-1:0]  w_pri;
    logic [NP_W-1:0]   w_pc_inc;
    logic              w_active;
    logic              w_arm;
    logic              w_on_time;
    logic              w_late;
    logic              w_tc;
    logic              w_fin;
    logic              w_restart;
    logic              w_wave_end;

    // Effective length is at least one sample; the PRI never cuts a waveform short
    assign w_len     = (bus.wave_len == '0) ? ADDR_W'(1) : bus.wave_len;
    assign w_len_ext = PRI_W'(w_len);
    assign w_pri     = (bus.pri_cycles < w_len_ext) ? w_len_ext : bus.pri_cycles;

    assign w_active   = (r_state == S_PLAY) || (r_state == S_GAP);
    assign w_arm      = (r_state == S_IDLE) && bus.arm;
    assign w_on_time  = (r_state == S_ARMED) && bus.tic && (bus.sec == r_start_sec);
    assign w_late     = (r_state == S_ARMED) && bus.tic && (bus.sec > r_start_sec);
    assign w_pc_inc   = r_pulse_cnt + 1'b1;
    assign w_fin      = w_tc && (r_num != '0) && (w_pc_inc == r_num);
    assign w_restart  = w_tc && !w_fin;
    // When L==P the terminal count lands on the last sample, so the restart wins and GAP is skipped
    assign w_wave_end = (r_state == S_PLAY) && !w_tc && (r_dac_addr == r_l_last);

    dac_seq_pri_cnt #(.W(PRI_W)) u_pri_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (!w_active),
        .i_en   (w_active),
        .i_last (r_p_last),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
        end else if (w_arm) begin
            w_state_nxt = S_ARMED;
        end else if (w_on_time || w_restart) begin
            w_state_nxt = S_PLAY;
        end else if (w_late || w_fin) begin
            w_state_nxt = S_IDLE;
        end else if (w_wave_end) begin
            w_state_nxt = S_GAP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_start_sec   <= '0;
            r_l_last      <= '0;
            r_p_last      <= '0;
            r_num         <= '0;
            r_pulse_cnt   <= '0;
            r_dac_addr    <= '0;
            r_dac_en      <= 1'b0;
            r_pulse_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_late_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_pulse_start <= 1'b0;
            r_done        <= 1'b0;
            r_late_err    <= 1'b0;
            if (bus.abort) begin
                r_dac_en   <= 1'b0;
                r_dac_addr <= '0;
            end else begin
                if (w_arm) begin
                    r_start_sec <= bus.start_sec;
                    r_l_last    <= w_len - 1'b1;
                    r_p_last    <= w_pri - 1'b1;
                    r_num       <= bus.num_pulses;
                end
                if (w_on_time || w_restart) begin
                    r_dac_en      <= 1'b1;
                    r_dac_addr    <= '0;
                    r_pulse_start <= 1'b1;
                    r_pulse_cnt   <= w_on_time ? '0 : w_pc_inc;
                end else if (w_fin || w_wave_end) begin
                    r_dac_en   <= 1'b0;
                    r_dac_addr <= '0;
                    r_done     <= w_fin;
                end else if (r_state == S_PLAY) begin
                    r_dac_addr <= r_dac_addr + 1'b1;
                end
                r_late_err <= w_late;
            end
        end
    end

`ifdef DAC_SEQ_LATE_CNT_EN
    logic [15:0] r_late_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_late_cnt <= '0;
        end else if (w_late && !bus.abort && (r_late_cnt != 16'hFFFF)) begin
            r_late_cnt <= r_late_cnt + 1'b1;
        end
    end

    assign bus.late_cnt = r_late_cnt;
`endif

    assign bus.dac_addr    = r_dac_addr;
    assign bus.dac_en      = r_dac_en;
    assign bus.pulse_start = r_pulse_start;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.late_err    = r_late_err;

endmodule

// File: tb/tb_dac_sequencer.sv
// tb/tb_dac_sequencer.sv - self-checking bench for dac_sequencer (late_cnt checks under DAC_SEQ_LATE_CNT_EN)
module tb_dac_sequencer;
    import dac_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_en = 0, n_ps = 0, n_done = 0, n_late = 0;

    always #5 clk = ~clk;

    dac_sequencer_if bus();
    dac_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pulse is "cycles since its start" k; en while k<L, next pulse after P cycles
    int     m_mode = 0;
    longint m_k = 0, m_np = 0, m_l = 1, m_p = 1, m_n = 0, m_ms = 0;
    int     m_lcnt = 0;
    logic   e_done = 1'b0, e_late = 1'b0;

    always @(posedge clk) begin
        e_done = 1'b0;
        e_late = 1'b0;
        if (rst) begin
            m_mode = 0;
            m_lcnt = 0;
        end else if (bus.abort) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (bus.arm) begin
                m_ms   = longint'(bus.start_sec);
                m_l    = (bus.wave_len == 0) ? 1 : longint'(bus.wave_len);
                m_p    = (longint'(bus.pri_cycles) < m_l) ? m_l : longint'(bus.pri_cycles);
                m_n    = longint'(bus.num_pulses);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (bus.tic) begin
                if (longint'(bus.sec) == m_ms) begin
                    m_mode = 2;
                    m_k    = 0;
                    m_np   = 0;
                end else if (longint'(bus.sec) > m_ms) begin
                    e_late = 1'b1;
                    m_mode = 0;
                    if (m_lcnt < 65535) m_lcnt++;
                end
            end
        end else begin
            if (m_k == m_p - 1) begin
                m_np++;
                if (m_n != 0 && m_np == m_n) begin
                    e_done = 1'b1;
                    m_mode = 0;
                end else begin
                    m_k = 0;
                end
            end else begin
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_en;
            e_en = (m_mode == 2) && (m_k < m_l);
            chk("dac_en", 32'(bus.dac_en), 32'(e_en));
            chk("dac_addr", 32'(bus.dac_addr), e_en ? 32'(m_k) : 32'd0);
            chk("pulse_start", 32'(bus.pulse_start), 32'((m_mode == 2) && (m_k == 0)));
            chk("busy", 32'(bus.busy), 32'(m_mode != 0));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("late_err", 32'(bus.late_err), 32'(e_late));
`ifdef DAC_SEQ_LATE_CNT_EN
            chk("late_cnt", 32'(bus.late_cnt), 32'(m_lcnt));
`endif
            if (bus.dac_en) n_en++;
            if (bus.pulse_start) n_ps++;
            if (bus.done) n_done++;
            if (bus.late_err) n_late++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Config inputs are scrambled after arm; the latched copy must be what plays
    task automatic do_arm(input logic [31:0] s, input logic [31:0] p, input logic [13:0] w, input logic [15:0] n);
        bus.arm = 1'b1;
        bus.start_sec = s;
        bus.pri_cycles = p;
        bus.wave_len = w;
        bus.num_pulses = n;
        @(negedge clk);
        bus.arm = 1'b0;
        bus.start_sec = 32'hFFFF_FFFF;
        bus.pri_cycles = 32'd1;
        bus.wave_len = 14'd1;
        bus.num_pulses = 16'd1;
    endtask

    task automatic do_tic(input logic [31:0] s);
        bus.tic = 1'b1;
        bus.sec = s;
        @(negedge clk);
        bus.tic = 1'b0;
    endtask

    initial begin
        bus.tic = 1'b0;
        bus.sec = '0;
        bus.arm = 1'b0;
        bus.abort = 1'b0;
        bus.start_sec = '0;
        bus.pri_cycles = '0;
        bus.wave_len = '0;
        bus.num_pulses = '0;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_en", 32'(bus.dac_en), 0);
        chk("rst_addr", 32'(bus.dac_addr), 0);
        chk("rst_done", 32'(bus.done), 0);

        // Basic run: L=4, P=10, three pulses
        do_arm(5, 10, 4, 3);
        chk("armed_busy", 32'(bus.busy), 1);
        do_tic(4);
        chk("early_tic_ps", 32'(bus.pulse_start), 0);
        chk("early_tic_busy", 32'(bus.busy), 1);
        do_tic(5);
        for (int i = 0; i < 30; i++) begin
            chk("basic_en", 32'(bus.dac_en), ((i % 10) < 4) ? 1 : 0);
            chk("basic_addr", 32'(bus.dac_addr), ((i % 10) < 4) ? (i % 10) : 0);
            chk("basic_ps", 32'(bus.pulse_start), ((i % 10) == 0) ? 1 : 0);
            @(negedge clk);
        end
        chk("basic_done", 32'(bus.done), 1);
        chk("basic_idle", 32'(bus.busy), 0);
        cyc(1);
        chk("basic_done_1cyc", 32'(bus.done), 0);

        // Clamping: P raised to L=8, back-to-back pulses
        n_en = 0; n_ps = 0; n_done = 0;
        do_arm(1, 4, 8, 2);
        do_tic(1);
        cyc(20);
        chk("clamp_en_cycles", 32'(n_en), 16);
        chk("clamp_pulses", 32'(n_ps), 2);
        chk("clamp_done", 32'(n_done), 1);
        chk("clamp_idle", 32'(bus.busy), 0);

        // Late starts
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        n_en = 0; n_late = 0;
        for (int r = 0; r < 3; r++) begin
            do_arm(3, 10, 4, 1);
            do_tic(7);
            chk("late_strobe", 32'(bus.late_err), 1);
            chk("late_idle", 32'(bus.busy), 0);
        end
        cyc(2);
        chk("late_count", 32'(n_late), 3);
        chk("late_no_en", 32'(n_en), 0);
`ifdef DAC_SEQ_LATE_CNT_EN
        chk("late_cnt_3", 32'(bus.late_cnt), 3);
`endif

        // Reset in the middle of playback
        do_arm(2, 10, 4, 0);
        do_tic(2);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_en", 32'(bus.dac_en), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_addr", 32'(bus.dac_addr), 0);
`ifdef DAC_SEQ_LATE_CNT_EN
        chk("late_cnt_rst", 32'(bus.late_cnt), 0);
`endif

        // Abort at dac_addr==2, then a re-arm
        n_done = 0;
        do_arm(10, 20, 6, 0);
        do_tic(10);
        cyc(2);
        chk("abort_at_addr", 32'(bus.dac_addr), 2);
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        chk("abort_en", 32'(bus.dac_en), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_no_done", 32'(n_done), 0);
        do_arm(11, 5, 2, 1);
        do_tic(11);
        chk("rearm_ps", 32'(bus.pulse_start), 1);
        cyc(5);
        chk("rearm_done", 32'(bus.done), 1);
        chk("rearm_idle", 32'(bus.busy), 0);

        // Arm/abort collision, then an ignored second arm
        bus.start_sec = 32'd99;
        bus.arm = 1'b1;
        bus.abort = 1'b1;
        cyc(1);
        bus.arm = 1'b0;
        bus.abort = 1'b0;
        chk("collide_idle", 32'(bus.busy), 0);
        do_arm(20, 6, 3, 1);
        chk("collide_rearm", 32'(bus.busy), 1);
        do_arm(21, 6, 3, 1);
        do_tic(20);
        chk("second_arm_ignored_ps", 32'(bus.pulse_start), 1);
        chk("second_arm_no_late", 32'(bus.late_err), 0);
        cyc(6);
        chk("collide_done", 32'(bus.done), 1);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
